// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding N requesters into one shared FIFO write port
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int N_REQ      = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic                        fifo_full_i,
  output logic                        fifo_write_o,
  output logic [DATA_WIDTH-1:0]       fifo_wr_data_o,
  output logic [N_REQ-1:0]            grant_o,
  output logic                        busy_o
);
  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [GW-1:0] G_LAST   = GW'(N_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);
  localparam logic [GW:0]   N_WIDE   = (GW + 1)'(N_REQ);
  localparam logic [N_REQ-1:0] ONE   = N_REQ'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_g;
  logic [GW-1:0]   r_rr;
  logic [CW-1:0]   r_cnt;

  logic                  w_busy;
  logic                  w_xfer;
  logic                  w_release;
  logic                  w_any;
  logic [GW-1:0]         w_next;
  logic [GW-1:0]         w_start;
  logic [GW-1:0]         w_off;
  logic [GW:0]           w_sum;
  logic [GW-1:0]         w_pick;
  logic [N_REQ-1:0]      w_rot;
  logic [N_REQ-1:0]      w_onehot;
  logic [DATA_WIDTH-1:0] w_words [N_REQ];

  genvar k;
  generate
    for (k = 0; k < N_REQ; k++) begin : g_words
      assign w_words[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_busy    = r_state == BUSY;
  assign w_xfer    = w_busy && req_valid_i[r_g] && !fifo_full_i;
  assign w_release = w_busy && (!req_valid_i[r_g] || (w_xfer && r_cnt == CNT_LAST));
  assign w_next    = (r_g == G_LAST) ? '0 : r_g + 1'b1;
  // On release the search starts just past the old grant, so the released requester ends up last in line
  assign w_start   = w_busy ? w_next : r_rr;
  assign w_rot     = N_REQ'({req_valid_i, req_valid_i} >> w_start);
  assign w_sum     = {1'b0, w_start} + {1'b0, w_off};
  assign w_pick    = (w_sum >= N_WIDE) ? GW'(w_sum - N_WIDE) : GW'(w_sum);
  assign w_onehot  = ONE << r_g;

  // first valid requester at or after the search start, as an offset from it
  always_comb begin
    w_any = 1'b0;
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_any = 1'b1;
        w_off = GW'(i);
      end
    end
  end

  // grant FSM: arbitrate from IDLE or on release, otherwise count transfers of the current burst
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_g     <= '0;
      r_rr    <= '0;
      r_cnt   <= '0;
    end else if (!w_busy || w_release) begin
      if (w_busy) r_rr <= w_next;
      r_state <= w_any ? BUSY : IDLE;
      if (w_any) begin
        r_g   <= w_pick;
        r_cnt <= '0;
      end
    end else if (w_xfer) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign busy_o         = w_busy;
  assign grant_o        = w_busy ? w_onehot : '0;
  assign fifo_write_o   = w_xfer;
  assign req_ready_o    = w_xfer ? w_onehot : '0;
  assign fifo_wr_data_o = w_busy ? w_words[r_g] : '0;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vector bench for the round-robin FIFO write arbiter
module tb_fifo_wr_arbiter;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int BL = 4;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    valid = '0;
  logic [N*DW-1:0] data;
  logic            full  = 1'b0;
  logic [N-1:0]    ready;
  logic [N-1:0]    grant;
  logic            wr;
  logic            busy;
  logic [DW-1:0]   wdata;

  int tests = 0;
  int fails = 0;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .BURST_LEN(BL)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .req_valid_i    (valid),
    .req_data_i     (data),
    .req_ready_o    (ready),
    .fifo_full_i    (full),
    .fifo_write_o   (wr),
    .fifo_wr_data_o (wdata),
    .grant_o        (grant),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            rst;
    logic [N-1:0]  v;
    logic          f;
    logic          wr;
    logic [N-1:0]  g;
    logic [DW-1:0] d;
    logic          b;
  } vec_t;

  vec_t tbl[$];

  task automatic add(bit rst, logic [N-1:0] v, logic f, logic w, logic [N-1:0] g, logic [DW-1:0] d, logic b);
    vec_t e;
    e.rst = rst; e.v = v; e.f = f; e.wr = w; e.g = g; e.d = d; e.b = b;
    tbl.push_back(e);
  endtask

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(string tag, logic w, logic [N-1:0] g, logic [DW-1:0] d, logic b);
    chk({tag, ".write"}, DW'(wr), DW'(w));
    chk({tag, ".ready"}, DW'(ready), DW'(w ? g : '0));
    chk({tag, ".grant"}, DW'(grant), DW'(g));
    chk({tag, ".data"}, wdata, d);
    chk({tag, ".busy"}, DW'(busy), DW'(b));
  endtask

  int           run_len = 0;
  logic [N-1:0] last_g  = '0;
  logic         sole    = 1'b0;

  // protocol watchdog sampled mid-cycle, away from both clock edges
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      run_len = 0;
      sole    = 1'b0;
    end else begin
      if (wr && full) begin
        fails++;
        $display("FAIL assert_write_when_full: write=%0b full=%0b", wr, full);
      end
      if (grant != '0 && !$onehot(grant)) begin
        fails++;
        $display("FAIL assert_grant_onehot: grant=%b", grant);
      end
      if (!$onehot0(ready)) begin
        fails++;
        $display("FAIL assert_ready_onehot: ready=%b", ready);
      end
      if (!wr) run_len = 0;
      else begin
        run_len = (grant != last_g || sole) ? 1 : run_len + 1;
        if (run_len > BL) begin
          fails++;
          $display("FAIL assert_burst_len: %0d consecutive writes, limit %0d", run_len, BL);
        end
      end
      last_g = grant;
      sole   = wr && (valid == grant);
    end
  end

  initial begin
    for (int k = 0; k < N; k++) data[k*DW +: DW] = DW'(k);
    valid = 4'hF;
    #3;
    chk_out("reset", 1'b0, '0, '0, 1'b0);

    // all four requesters valid: four-word bursts in order 0,1,2,3,0 with no gap
    add(1, 4'hF, 0, 0, 4'b0000, 0, 0);
    for (int g = 0; g < N; g++)
      for (int w = 0; w < BL; w++) add(0, 4'hF, 0, 1, N'(1) << g, DW'(g), 1);
    add(0, 4'hF, 0, 1, 4'b0001, 0, 1);
    // requester 2 drops after two words; pointer then sits at 3, so 3 beats 0
    add(1, 4'b0100, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b0100, 0, 1, 4'b0100, 2, 1);
    add(0, 4'b0100, 0, 1, 4'b0100, 2, 1);
    add(0, 4'b0000, 0, 0, 4'b0100, 2, 1);
    add(0, 4'b1001, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b1001, 0, 1, 4'b1000, 3, 1);
    // full for five cycles inside requester 1's burst; burst still totals four words
    add(1, 4'b0110, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b0110, 0, 1, 4'b0010, 1, 1);
    for (int c = 0; c < 5; c++) add(0, 4'b0110, 1, 0, 4'b0010, 1, 1);
    for (int c = 0; c < 3; c++) add(0, 4'b0110, 0, 1, 4'b0010, 1, 1);
    add(0, 4'b0110, 0, 1, 4'b0100, 2, 1);
    // requester 3 alone: back-to-back bursts, then pointer wrapped to 0 so 1 beats 3
    add(1, 4'b1000, 0, 0, 4'b0000, 0, 0);
    for (int c = 0; c < 2*BL + 1; c++) add(0, 4'b1000, 0, 1, 4'b1000, 3, 1);
    add(0, 4'b0000, 0, 0, 4'b1000, 3, 1);
    add(0, 4'b1010, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b1010, 0, 1, 4'b0010, 1, 1);

    foreach (tbl[i]) begin
      @(negedge clk);
      if (tbl[i].rst) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      valid = tbl[i].v;
      full  = tbl[i].f;
      #1;
      chk_out($sformatf("vec%0d", i), tbl[i].wr, tbl[i].g, tbl[i].d, tbl[i].b);
    end

    // asynchronous reset pulse during requester 0's third word
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    valid = 4'b0001;
    full  = 1'b0;
    #1;
    chk_out("async_idle", 1'b0, '0, '0, 1'b0);
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      #1;
      chk_out($sformatf("async_word%0d", w), 1'b1, 4'b0001, 0, 1'b1);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("async_drop", 1'b0, '0, '0, 1'b0);
    #1;
    rst_n = 1'b1;
    valid = 4'b0011;
    for (int w = 0; w < BL; w++) begin
      @(negedge clk);
      #1;
      chk_out($sformatf("post_reset_word%0d", w), 1'b1, 4'b0001, 0, 1'b1);
    end
    @(negedge clk);
    #1;
    chk_out("post_reset_next", 1'b1, 4'b0010, 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the word width of every data port.
REQ-002 The block SHALL have parameter N_REQ, default 4, giving the number of requesters; legal range is 2..16.
REQ-003 The block SHALL have parameter BURST_LEN, default 4, giving the maximum words per grant; legal range is 1..255.
REQ-004 clk_i  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst_n_i  in  1  SHALL be the reset, asynchronous and active-low.
REQ-006 req_valid_i  in  N_REQ  SHALL carry one valid bit per requester.
REQ-007 req_data_i  in  N_REQ*DATA_WIDTH  SHALL carry the requester words; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ready_o  out  N_REQ  SHALL be the per-requester word-accepted strobe.
REQ-009 fifo_full_i  in  1  SHALL be the full flag of the shared synchronous FIFO.
REQ-010 fifo_write_o  out  1  SHALL be the write strobe to the FIFO.
REQ-011 fifo_wr_data_o  out  DATA_WIDTH  SHALL be the write data to the FIFO.
REQ-012 grant_o  out  N_REQ  SHALL be the one-hot current grant, or all zeros when no grant is held.
REQ-013 busy_o  out  1  SHALL be high whenever the FSM is in BUSY.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE (no grant) and BUSY (grant register g valid).
REQ-015 In IDLE, if any req_valid_i bit is set, the block SHALL pick the first set bit searching upward from rr_ptr modulo N_REQ, load g, clear burst_cnt and enter BUSY at the next edge.
REQ-016 In IDLE, if no req_valid_i bit is set, the block SHALL remain in IDLE.
REQ-017 In BUSY, a transfer SHALL occur exactly when req_valid_i[g] is high and fifo_full_i is low.
REQ-018 A transfer SHALL be purely combinational from the registered g in the same cycle: fifo_write_o=1, req_ready_o[g]=1, fifo_wr_data_o = word g.
REQ-019 Outside a transfer, fifo_write_o and all req_ready_o bits SHALL be 0.
REQ-020 fifo_wr_data_o SHALL equal word g while in BUSY and SHALL be 0 in IDLE.
REQ-021 burst_cnt SHALL be $clog2(BURST_LEN+1) bits wide and SHALL increment by 1 on each transfer.
REQ-022 Release SHALL occur on (a) a transfer with burst_cnt == BURST_LEN-1, or (b) a BUSY cycle with req_valid_i[g] low.
REQ-023 On release, rr_ptr SHALL load (g+1) mod N_REQ, wrapping to 0 after N_REQ-1.
REQ-024 On release, the same edge SHALL re-arbitrate from (g+1) mod N_REQ using the current req_valid_i. If a bit is set, the FSM stays in BUSY with the new g and burst_cnt=0; otherwise it enters IDLE.
REQ-025 Within that re-arbitration the released requester SHALL have lowest priority and SHALL be regranted only if it is the sole valid requester.
REQ-026 While fifo_full_i is high in BUSY with req_valid_i[g] high, g, burst_cnt and rr_ptr SHALL hold, with no release and no transfer.
REQ-027 A requester SHALL hold its data stable while its valid is high until it sees ready; the block does not buffer words.
REQ-028 The block SHALL never assert fifo_write_o while fifo_full_i is high.
REQ-029 The block SHALL never assert more than one req_ready_o bit at a time.

Reset
REQ-030 Asserting rst_n_i low SHALL immediately, without waiting for a clock edge, force state=IDLE, g=0, rr_ptr=0 and burst_cnt=0.
REQ-031 During reset, all outputs SHALL be 0: fifo_write_o, req_ready_o, grant_o, busy_o and fifo_wr_data_o.
REQ-032 Reset asserted mid-burst SHALL discard the burst; the first post-reset grant SHALL follow REQ-015 from rr_ptr=0.

Verification
REQ-033 (Defaults) All four valid from reset, FIFO never full, each requester's data = its index -> FIFO receives 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,... with no idle cycle between bursts.
REQ-034 (Early release) Only requester 2 valid, dropping after 2 words -> exactly 2 writes, then IDLE, and rr_ptr=3.
REQ-035 (Backpressure) fifo_full_i high for 5 cycles mid-burst of requester 1 -> fifo_write_o stays 0, and grant_o=4'b0010 and burst_cnt hold throughout. The burst resumes and completes 4 words.
REQ-036 (Sole requester) Requester 3 alone continuously valid -> back-to-back 4-word bursts, with rr_ptr wrapping 3->0 each release and grant_o staying 4'b1000.
REQ-037 (Async reset) rst_n_i pulsed low between clock edges during requester 0's third word -> outputs drop to 0 before the next edge. After release, requesters 0 and 1 valid -> first grant to 0.
REQ-038 (Assertions) A bench assertion SHALL fire on any fifo_write_o while fifo_full_i is high, on a non-one-hot nonzero grant_o, or on more than BURST_LEN consecutive writes from one grant.
